// File: rtl/note_chart_sequencer.sv
// note_chart_sequencer: reads {lane,duration} chart entries from a 1-cycle-latency RAM, presents notes
// over valid/ready and holds each for duration*TICK_DIV cycles. Define NOTE_SEQ_LOOP_EN to loop forever.
module note_chart_sequencer #(
    parameter logic [15:0] BASE_ADDR   = 16'hF000,
    parameter int unsigned NUM_ENTRIES = 20,
    parameter int unsigned TICK_DIV    = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    output logic        note_valid,
    output logic [3:0]  note_lane,
    input  logic        note_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_PRESENT,
        S_HOLD,
        S_ADVANCE,
        S_END,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         entry_q, entry_d;
    logic [11:0]         hold_q, hold_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [3:0]          lane_q, lane_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            entry_q <= '0;
            hold_q  <= '0;
            tick_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            entry_q <= entry_d;
            hold_q  <= hold_d;
            tick_q  <= tick_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        entry_d    = entry_q;
        hold_d     = hold_q;
        tick_d     = tick_q;
        lane_d     = lane_q;
        mem_rd_en  = 1'b0;
        note_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                entry_d = mem_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                tick_d = '0;
                hold_d = entry_q[11:0];
                if (entry_q[11:0] == 12'd0) begin
                    state_d = S_END;
                end else if (entry_q[15:12] == 4'd0) begin
                    state_d = S_HOLD;
                end else begin
                    lane_d  = entry_q[15:12];
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                note_valid = 1'b1;
                if (note_ready) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // hold is never 0 here: zero durations are decoded as the end marker
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    hold_d = hold_q - 12'd1;
                    if (hold_q == 12'd1) begin
                        state_d = S_ADVANCE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_ADVANCE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_END;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_END: begin
`ifdef NOTE_SEQ_LOOP_EN
                idx_d   = '0;
                state_d = S_FETCH;
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr  = BASE_ADDR + 16'(idx_q);
    assign note_lane = lane_q;

endmodule

// File: tb/tb_note_chart_sequencer.sv
// Bench for note_chart_sequencer: timeline model of the chart walk checked every cycle, plus
// directed tests with hand-computed latencies. Honours NOTE_SEQ_LOOP_EN like the design.
module tb_note_chart_sequencer;

    localparam int unsigned N  = 3;
    localparam int unsigned TD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        note_ready = 1'b0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data = '0;
    logic        note_valid;
    logic [3:0]  note_lane;
    logic        busy;
    logic        done;

    logic [15:0] mem [4];

    int total = 0;
    int bad = 0;
    int hs = 0;
    bit chk_en = 1'b0;

    bit       ex_busy, ex_done, ex_valid, ex_rd;
    bit [3:0] ex_lane;
    int       m_idx = 0;
    bit       m_abort = 1'b0;

    note_chart_sequencer #(
        .BASE_ADDR  (16'hF000),
        .NUM_ENTRIES(N),
        .TICK_DIV   (TD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .note_valid(note_valid),
        .note_lane (note_lane),
        .note_ready(note_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr[1:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic setx(input bit b, input bit d, input bit v, input bit [3:0] l, input bit r);
        ex_busy  = b;
        ex_done  = d;
        ex_valid = v;
        ex_lane  = l;
        ex_rd    = r;
    endtask

    // Timeline of one chart walk; returns as soon as a reset is seen.
    task automatic m_run();
        logic [15:0] w;
        int unsigned dur;
        bit fin;
        forever begin
            do begin
                @(posedge clk);
                if (m_abort) return;
            end while (!start);
            m_idx = 0;
            forever begin
                setx(1, 0, 0, 0, 1);
                @(posedge clk); if (m_abort) return;
                setx(1, 0, 0, 0, 0);
                w = mem[m_idx];
                @(posedge clk); if (m_abort) return;
                @(posedge clk); if (m_abort) return;
                dur = int'(w[11:0]);
                fin = (dur == 0);
                if (!fin) begin
                    if (w[15:12] != 4'd0) begin
                        setx(1, 0, 1, w[15:12], 0);
                        do begin
                            @(posedge clk);
                            if (m_abort) return;
                        end while (!note_ready);
                        setx(1, 0, 0, 0, 0);
                    end
                    repeat (dur * TD) begin
                        @(posedge clk); if (m_abort) return;
                    end
                    @(posedge clk); if (m_abort) return;
                    fin = (m_idx == N - 1);
                    if (!fin) m_idx++;
                end
                if (fin) begin
                    setx(1, 0, 0, 0, 0);
                    @(posedge clk); if (m_abort) return;
`ifdef NOTE_SEQ_LOOP_EN
                    m_idx = 0;
`else
                    setx(0, 1, 0, 0, 0);
                    break;
`endif
                end
            end
        end
    endtask

    initial begin
        setx(0, 0, 0, 0, 0);
        forever begin
            m_abort = 1'b0;
            while (!reset) @(posedge clk);
            m_run();
        end
    end

    always @(negedge reset) begin
        m_abort = 1'b1;
        setx(0, 0, 0, 0, 0);
        m_idx = 0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(ex_busy));
            chk("done", 32'(done), 32'(ex_done));
            chk("note_valid", 32'(note_valid), 32'(ex_valid));
            chk("mem_rd_en", 32'(mem_rd_en), 32'(ex_rd));
            chk("mem_addr", 32'(mem_addr), 32'hF000 + 32'(m_idx));
            if (ex_valid) chk("note_lane", 32'(note_lane), 32'(ex_lane));
        end
    end

    always @(negedge clk) if (reset && note_valid && note_ready) hs++;

    function automatic bit sel(input int which);
        case (which)
            0:       return note_valid;
            1:       return done;
            default: return mem_rd_en;
        endcase
    endfunction

    task automatic wait_sig(input string nm, input int which, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sel(which) && n < maxc);
        if (!sel(which)) chk({nm, "_timeout"}, 32'(sel(which)), 32'd1);
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        drive_pt();
        start = 1'b1;
        drive_pt();
        start = 1'b0;
    endtask

    int n, hs0;

    initial begin
        mem[0] = 16'h0; mem[1] = 16'h0; mem[2] = 16'h0; mem[3] = 16'h0;
        drive_pt();
        chk_en = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'hF000);
        drive_pt();
        drive_pt();
        reset = 1'b1;
        repeat (3) drive_pt();

        // single note, ready tied high
        mem[0] = {4'h4, 12'd3}; mem[1] = 16'h0000;
        note_ready = 1'b1;
        pulse_start();
        wait_sig("lat_a", 0, 20, n);
        chk("lat_a", 32'(n), 32'd4);
        chk("lane_a", 32'(note_lane), 32'h4);
        wait_sig("next_fetch", 2, 20, n);
        chk("accept_to_fetch", 32'(n), 32'd8);
        chk("fetch_addr", 32'(mem_addr), 32'hF001);
        wait_sig("done_a", 1, 50, n);

        // backpressure: ready low for 10 cycles
        mem[0] = {4'h2, 12'd1}; mem[1] = 16'h0000;
        note_ready = 1'b0;
        hs0 = hs;
        pulse_start();
        wait_sig("lat_b", 0, 20, n);
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", 32'(note_valid), 32'd1);
            chk("stall_lane", 32'(note_lane), 32'h2);
            chk("stall_noread", 32'(mem_rd_en), 32'd0);
        end
        drive_pt();
        note_ready = 1'b1;
        wait_sig("done_b", 1, 50, n);
        chk("hs_b", 32'(hs - hs0), 32'd1);

        // rest then note
        mem[0] = {4'h0, 12'd2}; mem[1] = {4'h3, 12'd1}; mem[2] = 16'h0000;
        pulse_start();
        wait_sig("lat_c", 0, 40, n);
        chk("lat_c", 32'(n), 32'd12);
        chk("lane_c", 32'(note_lane), 32'h3);
        wait_sig("done_c", 1, 50, n);

        // end marker at entry 2, stray start while busy, restart from DONE
        mem[0] = {4'h1, 12'd1}; mem[1] = {4'h2, 12'd1}; mem[2] = {4'h5, 12'd0};
        hs0 = hs;
        pulse_start();
        pulse_start();
        wait_sig("done_d", 1, 80, n);
        chk("done_d", 32'(done), 32'd1);
        chk("idle_d", 32'(busy), 32'd0);
        chk("addr_d", 32'(mem_addr), 32'hF002);
        chk("hs_d", 32'(hs - hs0), 32'd2);
        pulse_start();
        @(negedge clk);
        chk("restart_rd", 32'(mem_rd_en), 32'd1);
        chk("restart_addr", 32'(mem_addr), 32'hF000);
        wait_sig("done_d2", 1, 80, n);

        // all entries non-zero: finish after the last entry, or wrap when looping
        mem[0] = {4'h1, 12'd1}; mem[1] = {4'h2, 12'd1}; mem[2] = {4'h3, 12'd1};
        hs0 = hs;
        pulse_start();
`ifdef NOTE_SEQ_LOOP_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_rd_en && mem_addr == 16'hF002) && n < 100);
        chk("loop_last_read", 32'(mem_rd_en), 32'd1);
        wait_sig("loop_wrap", 2, 40, n);
        chk("loop_wrap_addr", 32'(mem_addr), 32'hF000);
        chk("loop_no_done", 32'(done), 32'd0);
`else
        wait_sig("done_e", 1, 100, n);
        chk("addr_e", 32'(mem_addr), 32'hF002);
        chk("hs_e", 32'(hs - hs0), 32'd3);
        pulse_start();
`endif

        // asynchronous reset in the middle of a hold
        wait_sig("lat_r", 0, 20, n);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(note_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'hF000);
        chk("rst_lane", 32'(note_lane), 32'd0);
        drive_pt();
        drive_pt();
        reset = 1'b1;
        repeat (4) drive_pt();
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
